// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
//  Module      : serial_subtractor
//  Description : Bit-serial N-bit subtractor. Computes A - B - borrow_in one
//                bit per clock, LSB first, through a single full-subtractor
//                cell and a borrow flip-flop. Uses a start/ready request
//                handshake and a valid/ack result handshake.
//
//  Parameters  : N             operand/result width in bits (N >= 1)
//
//  Ports       : i_clk         clock, rising edge
//                i_rst_n       asynchronous active-low reset
//                i_start       request, accepted only while o_ready=1
//                i_a           minuend, sampled on the accept edge
//                i_b           subtrahend, sampled on the accept edge
//                i_borrow_in   borrow into bit 0, sampled on the accept edge
//                o_ready       1 while idle
//                o_valid       1 while a result is presented
//                i_ack         result consumed, acted on only while o_valid=1
//                o_diff        (A - B - borrow_in) mod 2^N
//                o_borrow_out  1 iff A < B + borrow_in (unsigned)
//                o_overflow    two's-complement overflow
//                              (only when SERIAL_SUB_OVF_EN is defined)
//
//  Build macro : SERIAL_SUB_OVF_EN - adds the o_overflow port and its logic
//
//  Revision    : 1.0 - initial release
// ============================================================================
module serial_subtractor #(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_start,
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_borrow_in,
    output logic         o_ready,
    output logic         o_valid,
    input  logic         i_ack,
    output logic [N-1:0] o_diff,
    output logic         o_borrow_out
`ifdef SERIAL_SUB_OVF_EN
    ,
    output logic         o_overflow
`endif
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // A one-bit operand still needs a one-bit counter (it just never counts).
    localparam int               C_CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_LAST = C_CNT_W'(N - 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // ------------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------------
    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;

    logic [N-1:0]       r_a_sh;
    logic [N-1:0]       r_b_sh;
    logic [N-1:0]       r_d_sh;
    logic               r_borrow;
    logic [C_CNT_W-1:0] r_cnt;

    logic [N-1:0]       r_diff;
    logic               r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    logic               r_overflow;
`endif

    // ------------------------------------------------------------------------
    // Full-subtractor cell
    // ------------------------------------------------------------------------
    logic         w_bit_a;
    logic         w_bit_b;
    logic         w_d;
    logic         w_borrow_nxt;
    logic         w_cnt_last;
    logic [N-1:0] w_d_sh_nxt;

    assign w_bit_a      = r_a_sh[0];
    assign w_bit_b      = r_b_sh[0];
    assign w_d          = w_bit_a ^ w_bit_b ^ r_borrow;
    assign w_borrow_nxt = (~w_bit_a & w_bit_b) |
                          (~w_bit_a & r_borrow) |
                          (w_bit_b  & r_borrow);
    assign w_cnt_last   = (r_cnt == C_CNT_LAST);

    // Result bits enter at the MSB end so that after N shifts the first
    // (least significant) bit has arrived at position 0. A one-bit build has
    // nothing to shift in from above, so the slice is avoided there.
    generate
        if (N == 1) begin : g_dsh_single
            assign w_d_sh_nxt = w_d;
        end else begin : g_dsh_multi
            assign w_d_sh_nxt = {w_d, r_d_sh[N-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (w_cnt_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                // A start request arriving with the ack is not queued; the
                // next operation must be requested again once idle.
                if (i_ack) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_a_sh       <= '0;
            r_b_sh       <= '0;
            r_d_sh       <= '0;
            r_borrow     <= 1'b0;
            r_cnt        <= '0;
            r_diff       <= '0;
            r_borrow_out <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            r_overflow   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_a_sh   <= i_a;
                        r_b_sh   <= i_b;
                        r_d_sh   <= '0;
                        r_borrow <= i_borrow_in;
                        r_cnt    <= '0;
                    end
                end
                S_RUN: begin
                    r_a_sh   <= r_a_sh >> 1;
                    r_b_sh   <= r_b_sh >> 1;
                    r_d_sh   <= w_d_sh_nxt;
                    r_borrow <= w_borrow_nxt;
                    if (w_cnt_last) begin
                        // Published result only changes here, so it holds
                        // through DONE and the following idle period.
                        r_diff       <= w_d_sh_nxt;
                        r_borrow_out <= w_borrow_nxt;
`ifdef SERIAL_SUB_OVF_EN
                        // On the last bit r_borrow is the borrow into the
                        // MSB and w_borrow_nxt the borrow out of it.
                        r_overflow   <= r_borrow ^ w_borrow_nxt;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign o_ready      = (r_state == S_IDLE);
    assign o_valid      = (r_state == S_DONE);
    assign o_diff       = r_diff;
    assign o_borrow_out = r_borrow_out;
`ifdef SERIAL_SUB_OVF_EN
    assign o_overflow   = r_overflow;
`endif

endmodule
`default_nettype wire
